// File: rtl/lsu_bus_wb_gen_pkg.sv
// Shared widths, access-size encodings and the issue-queue entry layout for the LSU bus writeback path.
package lsu_bus_wb_gen_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned ROB_INDEX_WIDTH    = 6;
    localparam int unsigned PHY_REG_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_D = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    rob_index;
        logic                          is_load;
        logic [PHY_REG_ADDR_WIDTH-1:0] rd_addr;
        logic                          is_float;
        lsu_size_e                     size;
        logic                          is_unsigned;
        logic [2:0]                    offset;
    } bus_wb_entry_t;

endpackage

// File: rtl/lsu_bus_load_fmt.sv
// Combinational load alignment and sign/zero extension.
// Optional NaN-boxing of single-precision FP loads: LSU_BUS_WB_FP_NANBOX_EN.
module lsu_bus_load_fmt #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic            is_float,
    input  logic [2:0]      offset,
    output logic [XLEN-1:0] result
);
    import lsu_bus_wb_gen_pkg::*;

    logic [XLEN-1:0] sh;

    always_comb begin
        sh     = data >> {offset, 3'b000};
        result = sh;
        case (size)
            LSU_SIZE_B: result = {{(XLEN-8){~is_unsigned & sh[7]}}, sh[7:0]};
            LSU_SIZE_H: result = {{(XLEN-16){~is_unsigned & sh[15]}}, sh[15:0]};
            LSU_SIZE_W: result = {{(XLEN-32){~is_unsigned & sh[31]}}, sh[31:0]};
            default:    result = sh;
        endcase
`ifdef LSU_BUS_WB_FP_NANBOX_EN
        if (is_float && size == LSU_SIZE_W) begin
            result = {{(XLEN-32){1'b1}}, sh[31:0]};
        end
`else
        if (is_float) begin
            result = result;
        end
`endif
    end

endmodule

// File: rtl/lsu_bus_wb_gen.sv
// In-order tracker for uncached/MMIO bus accesses feeding the writeback arbiter, with flush drain.
// Optional feature macro: LSU_BUS_WB_FP_NANBOX_EN (NaN-box FP word loads).
module lsu_bus_wb_gen #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned ROB_INDEX_WIDTH    = 6,
    parameter int unsigned PHY_REG_ADDR_WIDTH = 6,
    parameter int unsigned BUS_WB_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          lsq_bus_wb_issue_vld_i,
    output logic                          lsq_bus_wb_issue_rdy_o,
    input  logic [ROB_INDEX_WIDTH-1:0]    lsq_bus_wb_issue_rob_index_i,
    input  logic                          lsq_bus_wb_issue_is_load_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] lsq_bus_wb_issue_rd_addr_i,
    input  logic                          lsq_bus_wb_issue_is_float_i,
    input  logic [1:0]                    lsq_bus_wb_issue_size_i,
    input  logic                          lsq_bus_wb_issue_unsigned_i,
    input  logic [2:0]                    lsq_bus_wb_issue_offset_i,
    input  logic                          bus_resp_vld_i,
    input  logic [XLEN-1:0]               bus_resp_data_i,
    output logic                          bus_resp_rdy_o,
    output logic                          bus_wb_arb_wb_vld_o,
    output logic [ROB_INDEX_WIDTH-1:0]    bus_wb_arb_wb_rob_index_o,
    output logic                          bus_wb_arb_prf_wb_vld_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] bus_wb_arb_prf_wb_rd_addr_o,
    output logic                          bus_wb_arb_prf_wb_is_float_o,
    output logic [XLEN-1:0]               bus_wb_arb_prf_wb_data_o,
    input  logic                          wb_arb_bus_rdy_i
);
    import lsu_bus_wb_gen_pkg::*;

    localparam int unsigned AW = $clog2(BUS_WB_DEPTH);
    localparam int unsigned DW = $clog2(BUS_WB_DEPTH + 1);
    localparam int unsigned SW = AW + 2;

    bus_wb_entry_t                 queue [BUS_WB_DEPTH];
    bus_wb_entry_t                 head;
    bus_wb_entry_t                 new_entry;
    logic [AW:0]                   wr_ptr, rd_ptr, cnt;
    logic [DW-1:0]                 drop_cnt;
    logic [SW-1:0]                 occupancy;
    logic                          issue_fire, resp_fire, drop_hit, q_hit;
    logic [XLEN-1:0]               fmt_data;

    logic                          out_vld, out_prf_vld, out_is_float;
    logic [ROB_INDEX_WIDTH-1:0]    out_rob_index;
    logic [PHY_REG_ADDR_WIDTH-1:0] out_rd_addr;
    logic [XLEN-1:0]               out_data;

    always_comb begin
        cnt        = wr_ptr - rd_ptr;
        occupancy  = SW'(cnt) + SW'(drop_cnt);
        head       = queue[rd_ptr[AW-1:0]];
        lsq_bus_wb_issue_rdy_o = occupancy < SW'(BUS_WB_DEPTH);
        bus_resp_rdy_o = (drop_cnt != '0) | ~out_vld | wb_arb_bus_rdy_i;
        issue_fire = lsq_bus_wb_issue_vld_i & lsq_bus_wb_issue_rdy_o & ~flush;
        resp_fire  = bus_resp_vld_i & bus_resp_rdy_o;
        drop_hit   = resp_fire & (drop_cnt != '0);
        q_hit      = resp_fire & (drop_cnt == '0) & (cnt != '0);

        new_entry.rob_index   = lsq_bus_wb_issue_rob_index_i;
        new_entry.is_load     = lsq_bus_wb_issue_is_load_i;
        new_entry.rd_addr     = lsq_bus_wb_issue_rd_addr_i;
        new_entry.is_float    = lsq_bus_wb_issue_is_float_i;
        new_entry.size        = lsu_size_e'(lsq_bus_wb_issue_size_i);
        new_entry.is_unsigned = lsq_bus_wb_issue_unsigned_i;
        new_entry.offset      = lsq_bus_wb_issue_offset_i;
    end

    lsu_bus_load_fmt #(.XLEN(XLEN)) u_fmt (
        .data        (bus_resp_data_i),
        .size        (head.size),
        .is_unsigned (head.is_unsigned),
        .is_float    (head.is_float),
        .offset      (head.offset),
        .result      (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            queue[wr_ptr[AW-1:0]] <= new_entry;
        end
    end

    // On flush every live queue entry still owes a bus response, so it moves into drop_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= drop_cnt - DW'(drop_hit) + DW'(cnt) - DW'(q_hit);
        end else begin
            if (issue_fire) wr_ptr <= wr_ptr + 1'b1;
            if (q_hit)      rd_ptr <= rd_ptr + 1'b1;
            if (drop_hit)   drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_vld       <= 1'b0;
            out_prf_vld   <= 1'b0;
            out_rob_index <= '0;
            out_rd_addr   <= '0;
            out_is_float  <= 1'b0;
            out_data      <= '0;
        end else if (q_hit) begin
            out_vld       <= 1'b1;
            out_prf_vld   <= head.is_load;
            out_rob_index <= head.rob_index;
            out_rd_addr   <= head.is_load ? head.rd_addr : '0;
            out_is_float  <= head.is_load & head.is_float;
            out_data      <= head.is_load ? fmt_data : '0;
        end else if (wb_arb_bus_rdy_i) begin
            out_vld     <= 1'b0;
            out_prf_vld <= 1'b0;
        end
    end

    assign bus_wb_arb_wb_vld_o          = out_vld;
    assign bus_wb_arb_wb_rob_index_o    = out_rob_index;
    assign bus_wb_arb_prf_wb_vld_o      = out_prf_vld;
    assign bus_wb_arb_prf_wb_rd_addr_o  = out_rd_addr;
    assign bus_wb_arb_prf_wb_is_float_o = out_is_float;
    assign bus_wb_arb_prf_wb_data_o     = out_data;

    // A response with nothing outstanding is a bus protocol violation; it is discarded.
    orphan_resp_a: assert property (@(posedge clk) disable iff (rst)
        !(resp_fire && drop_cnt == '0 && cnt == '0));

endmodule
